// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// The one-hot helper turns a register index into a 16-bit pending mask bit.
package regfile_pkg;

    localparam int NREG  = 16;
    localparam int REG_W = 4;

    localparam int              DATA_W_DEF    = 32;
    localparam logic [NREG-1:0] PROT_MASK_DEF = 16'hC000;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    function automatic logic [NREG-1:0] reg_onehot(input logic [REG_W-1:0] r);
        logic [NREG-1:0] one;
        one = {{(NREG-1){1'b0}}, 1'b1};
        return one << r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of {reg, data} entries for one write-back source.
// Exposes per-entry valid and register fields so the top can build the pending mask.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = REG_W + DATA_W_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [W-1:0]                din_i,
    output logic [W-1:0]                head_o,
    output logic [CW-1:0]               count_o,
    output logic [DEPTH-1:0]            valid_o,
    output logic [DEPTH-1:0][REG_W-1:0] regs_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] off;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset: entries are only observed through valid_o.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    always_comb begin
        valid_o = '0;
        regs_o  = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = AW'(i) - rd_ptr_q;
            valid_o[i] = ({1'b0, off} < count_q);
            regs_o[i]  = mem_q[i][W-1 -: REG_W];
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register file's single write port
// between the ALU (A) and load (B) paths, with protected-register filtering.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int              DEPTH     = 2,
    parameter int              DATA_W    = DATA_W_DEF,
    parameter logic [NREG-1:0] PROT_MASK = PROT_MASK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_W-1:0]  a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_W-1:0]  b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              writeEnable,
    output logic [REG_W-1:0]  dReg,
    output logic [DATA_W-1:0] wrData,
    output logic              wb_src,
    output logic [NREG-1:0]   pending,
    output logic              protErr
);

    localparam int EW = REG_W + DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [EW-1:0]               a_head, b_head, head_sel;
    logic [CW-1:0]               a_count, b_count;
    logic [DEPTH-1:0]            a_vld, b_vld;
    logic [DEPTH-1:0][REG_W-1:0] a_regs, b_regs;

    logic a_fire, b_fire, a_prot, b_prot, a_push, b_push;
    logic a_pop, b_pop, any_pop;
    src_e sel;

    logic              en_q;
    src_e              rr_q, rr_d;
    logic              we_q;
    logic [REG_W-1:0]  dreg_q;
    logic [DATA_W-1:0] wrdata_q;
    src_e              src_q;
    logic              prot_err_q, prot_err_d;
    logic [NREG-1:0]   pending_d;

    // Handshake: a transfer happens on a posedge where valid && ready. ready is a
    // function of queue occupancy and the post-reset enable only, never of a
    // same-cycle pop, so a full queue stays not-ready while it drains.
    assign a_ready = en_q && (a_count < DEPTH_C);
    assign b_ready = en_q && (b_count < DEPTH_C);

    assign a_fire = a_valid && a_ready;
    assign b_fire = b_valid && b_ready;
    assign a_prot = PROT_MASK[a_reg];
    assign b_prot = PROT_MASK[b_reg];
    assign a_push = a_fire && !a_prot;
    assign b_push = b_fire && !b_prot;
    assign prot_err_d = (a_fire && a_prot) || (b_fire && b_prot);

    // Eligibility uses pre-edge occupancy, so a push into an empty queue waits a cycle.
    always_comb begin
        a_pop    = 1'b0;
        b_pop    = 1'b0;
        sel      = SRC_A;
        rr_d     = rr_q;
        head_sel = a_head;
        if (a_count != '0 && b_count != '0) begin
            sel = rr_q;
        end else if (b_count != '0) begin
            sel = SRC_B;
        end
        any_pop = (a_count != '0) || (b_count != '0);
        if (any_pop) begin
            a_pop    = (sel == SRC_A);
            b_pop    = (sel == SRC_B);
            head_sel = (sel == SRC_B) ? b_head : a_head;
            rr_d     = (sel == SRC_A) ? SRC_B : SRC_A;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q       <= 1'b0;
            rr_q       <= SRC_A;
            we_q       <= 1'b0;
            dreg_q     <= '0;
            wrdata_q   <= '0;
            src_q      <= SRC_A;
            prot_err_q <= 1'b0;
        end else begin
            en_q       <= 1'b1;
            rr_q       <= rr_d;
            we_q       <= any_pop;
            prot_err_q <= prot_err_d;
            if (any_pop) begin
                dreg_q   <= head_sel[EW-1 -: REG_W];
                wrdata_q <= head_sel[DATA_W-1:0];
                src_q    <= sel;
            end
        end
    end

    always_comb begin
        pending_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_vld[i]) pending_d = pending_d | reg_onehot(a_regs[i]);
            if (b_vld[i]) pending_d = pending_d | reg_onehot(b_regs[i]);
        end
        if (we_q) pending_d = pending_d | reg_onehot(dreg_q);
    end

    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo_a (
        .clk     (clk),
        .reset   (reset),
        .push_i  (a_push),
        .pop_i   (a_pop),
        .din_i   ({a_reg, a_data}),
        .head_o  (a_head),
        .count_o (a_count),
        .valid_o (a_vld),
        .regs_o  (a_regs)
    );

    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo_b (
        .clk     (clk),
        .reset   (reset),
        .push_i  (b_push),
        .pop_i   (b_pop),
        .din_i   ({b_reg, b_data}),
        .head_o  (b_head),
        .count_o (b_count),
        .valid_o (b_vld),
        .regs_o  (b_regs)
    );

    assign writeEnable = we_q;
    assign dReg        = dreg_q;
    assign wrData      = wrdata_q;
    assign wb_src      = src_q;
    assign pending     = pending_d;
    assign protErr     = prot_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [3:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        writeEnable;
    logic [3:0]  dReg;
    logic [31:0] wrData;
    logic        wb_src;
    logic [15:0] pending;
    logic        protErr;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: per-source FIFOs of {reg, data} plus issue outputs.
    logic [35:0] aq[$];
    logic [35:0] bq[$];
    bit          m_en, m_rr, m_we, m_src, m_perr, m_fa, m_fb;
    logic [3:0]  m_dreg;
    logic [31:0] m_wrdata;

    logic [3:0] exp_q[$];
    logic [3:0] obs[$];

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_reg       (a_reg),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_reg       (b_reg),
        .b_data      (b_data),
        .writeEnable (writeEnable),
        .dReg        (dReg),
        .wrData      (wrData),
        .wb_src      (wb_src),
        .pending     (pending),
        .protErr     (protErr)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_prot(input logic [3:0] r);
        return (r == 4'd14) || (r == 4'd15);
    endfunction

    function automatic logic [15:0] model_pending();
        logic [15:0] p;
        p = '0;
        foreach (aq[i]) p[aq[i][35:32]] = 1'b1;
        foreach (bq[i]) p[bq[i][35:32]] = 1'b1;
        if (m_we) p[m_dreg] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        aq.delete();
        bq.delete();
        m_en = 0; m_rr = 0; m_we = 0; m_src = 0; m_perr = 0;
        m_fa = 0; m_fb = 0; m_dreg = '0; m_wrdata = '0;
    endtask

    task automatic model_step();
        bit ra, rb, fa, fb, na, nb, g;
        logic [35:0] e;
        ra = m_en && (aq.size() < DEPTH);
        rb = m_en && (bq.size() < DEPTH);
        fa = a_valid && ra;
        fb = b_valid && rb;
        m_fa = fa;
        m_fb = fb;
        na = (aq.size() != 0);
        nb = (bq.size() != 0);
        g  = (na && nb) ? m_rr : nb;
        if (na || nb) begin
            if (g) e = bq.pop_front();
            else   e = aq.pop_front();
            m_we = 1; m_dreg = e[35:32]; m_wrdata = e[31:0]; m_src = g; m_rr = !g;
        end else begin
            m_we = 0;
        end
        if (fa && !is_prot(a_reg)) aq.push_back({a_reg, a_data});
        if (fb && !is_prot(b_reg)) bq.push_back({b_reg, b_data});
        m_perr = (fa && is_prot(a_reg)) || (fb && is_prot(b_reg));
        m_en = 1;
    endtask

    // Scoreboard compare
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        check("a_ready", a_ready, m_en && (aq.size() < DEPTH));
        check("b_ready", b_ready, m_en && (bq.size() < DEPTH));
        check("writeEnable", writeEnable, m_we);
        check("dReg", dReg, m_dreg);
        check("wrData", wrData, m_wrdata);
        check("wb_src", wb_src, m_src);
        check("pending", pending, model_pending());
        check("protErr", protErr, m_perr);
    endtask

    // Driver tasks
    task automatic drive_idle();
        a_valid = 0; b_valid = 0;
        a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Called at a negedge: asserts reset, holds it two cycles, releases.
    task automatic do_reset();
        reset = 0;
        drive_idle();
        model_reset();
        #1;
        compare_all();
        check("rst_we_lit", writeEnable, 1'b0);
        check("rst_pending_lit", pending, 16'h0000);
        check("rst_ready_lit", {a_ready, b_ready}, 2'b00);
        cycle();
        cycle();
        reset = 1;
        #1;
        check("rel_ready0_lit", {a_ready, b_ready}, 2'b00);
        cycle();
        check("rel_ready1_lit", {a_ready, b_ready}, 2'b11);
        check("rel_we_lit", writeEnable, 1'b0);
    endtask

    initial begin
        int ia, ib, first, last;
        logic [3:0] e;
        drive_idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Single A write r3 = DEADBEEF
        a_valid = 1; a_reg = 4'd3; a_data = 32'hDEADBEEF;
        cycle();
        drive_idle();
        check("t1_pending_q", pending, 16'h0008);
        check("t1_we0", writeEnable, 1'b0);
        cycle();
        check("t1_we1", writeEnable, 1'b1);
        check("t1_dreg", dReg, 4'd3);
        check("t1_data", wrData, 32'hDEADBEEF);
        check("t1_src", wb_src, 1'b0);
        check("t1_pending_issue", pending, 16'h0008);
        cycle();
        check("t1_we_drop", writeEnable, 1'b0);
        check("t1_pending_clear", pending, 16'h0000);

        // Both sources continuously valid: A r1..r6, B r7..r12
        do_reset();
        exp_q = '{4'd1, 4'd7, 4'd2, 4'd8, 4'd3, 4'd9, 4'd4, 4'd10, 4'd5, 4'd11, 4'd6, 4'd12};
        obs.delete();
        ia = 0; ib = 0; first = -1; last = -1;
        begin
            bit saw_full;
            saw_full = 0;
            for (int c = 0; c < 40; c++) begin
                a_valid = (ia < 6); a_reg = 4'(1 + ia); a_data = 32'hA000_0000 + 32'(ia);
                b_valid = (ib < 6); b_reg = 4'(7 + ib); b_data = 32'hB000_0000 + 32'(ib);
                cycle();
                if (m_fa) ia++;
                if (m_fb) ib++;
                if (!a_ready || !b_ready) saw_full = 1;
                if (writeEnable) begin
                    obs.push_back(dReg);
                    if (first < 0) first = c;
                    last = c;
                end
                if (ia == 6 && ib == 6 && obs.size() == 12) break;
            end
            drive_idle();
            check("t2_saw_full", saw_full, 1'b1);
        end
        check("t2_count", obs.size(), 12);
        check("t2_back_to_back", last - first, 11);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("t2_order", (obs.size() != 0) ? obs.pop_front() : 4'hx, e);
        end
        cycle();

        // Protected targets from both sources in one cycle
        a_valid = 1; a_reg = 4'd15; a_data = 32'h1111_1111;
        b_valid = 1; b_reg = 4'd14; b_data = 32'h2222_2222;
        check("t3_ready_lit", {a_ready, b_ready}, 2'b11);
        cycle();
        drive_idle();
        check("t3_perr1", protErr, 1'b1);
        check("t3_we", writeEnable, 1'b0);
        check("t3_pending", pending, 16'h0000);
        cycle();
        check("t3_perr0", protErr, 1'b0);
        check("t3_we2", writeEnable, 1'b0);

        // Fill A to full, then reset mid-stream
        do_reset();
        ia = 0; ib = 0;
        for (int c = 0; c < 3; c++) begin
            a_valid = 1; a_reg = 4'(1 + ia); a_data = 32'(ia);
            b_valid = 1; b_reg = 4'(7 + ib); b_data = 32'(ib);
            cycle();
            if (m_fa) ia++;
            if (m_fb) ib++;
        end
        check("t4_a_full", a_ready, 1'b0);
        do_reset();
        check("t4_pending", pending, 16'h0000);
        a_valid = 1; a_reg = 4'd5; a_data = 32'd7;
        cycle();
        drive_idle();
        check("t4_we0", writeEnable, 1'b0);
        check("t4_pend5", pending, 16'h0020);
        cycle();
        check("t4_we1", writeEnable, 1'b1);
        check("t4_dreg", dReg, 4'd5);
        check("t4_data", wrData, 32'd7);

        // Randomized traffic with a reset in the middle
        for (int c = 0; c < 300; c++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
            a_reg = 4'($urandom_range(0, 15));
            b_reg = 4'($urandom_range(0, 15));
            a_data = $urandom;
            b_data = $urandom;
            cycle();
            if (c == 150) do_reset();
        end
        drive_idle();
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 16 x 32 register file. Two write-back sources share the register file's single write port: A is the ALU result path and B is the load path. Each source has a small queue, sources are granted round-robin, and writes to protected registers r14/r15 are filtered out. A per-register pending mask feeds the decode stage's hazard check.

## Interface
- DEPTH, 2: entries per source queue (power of 2, ≥2)
- DATA_W, 32: write data width
- PROT_MASK, 16'hC000: registers whose writes are dropped (r14, r15)
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately
- a_valid / b_valid  in  1  source write request
- a_ready / b_ready  out  1  source may transfer this cycle
- a_reg / b_reg  in  4  destination register
- a_data / b_data  in  DATA_W  write data
- writeEnable  out  1  to register file; registered
- dReg  out  4  to register file; registered
- wrData  out  DATA_W  to register file; registered
- wb_src  out  1  source of the current write (0=A, 1=B)
- pending  out  16  bit r is 1 while any queued or issuing write targets r
- protErr  out  1  one-cycle pulse: an accepted request targeted a PROT_MASK register

## Operation
- **Handshake.**
  - A transfer occurs on a posedge with valid && ready.
  - ready = (count < DEPTH) && en. `en` is a flag cleared by reset and set on the first posedge after release.
  - ready does not depend on a same-cycle pop. A full queue deasserts ready even while it is draining.
- **Protected target.** A transfer to a PROT_MASK register completes the handshake but is not enqueued. protErr = 1 in the following cycle. Transfers to protected registers from both sources in the same cycle produce a single protErr pulse.
- **Queues.** Each source has a FIFO of {reg, data}. Order within a source is preserved.
- **Arbitration.**
  - Each cycle at most one head is popped.
  - If exactly one queue is non-empty, its head is popped.
  - If both are non-empty, the head of the source named by the priority pointer `rr` is popped. After any grant, `rr` flips to the other source.
- **Issue.** The popped entry is registered on the same posedge as writeEnable = 1, dReg, wrData and wb_src. With no pop, writeEnable = 0 and dReg/wrData/wb_src hold their previous values.
- **pending.** OR of one-hot decodes of every valid queue entry plus dReg while writeEnable = 1. It is derived only from state, with no path from inputs.
- **Cross-source order.** Writes from A and B to the same register are not ordered. Upstream must not issue a write to r while pending[r] = 1 from the other source.
- **Reset (asserted).** Queues empty, rr = A, en = 0, writeEnable = 0, dReg = 0, wrData = 0, wb_src = 0, protErr = 0, pending = 0, a_ready = b_ready = 0. Reset mid-operation discards all queued writes.

## Timing
- Latency: a transfer on posedge N produces writeEnable = 1 after posedge N+1 at the earliest. The register file captures the write at the following negedge, within the same cycle.
- Throughput: one write per cycle in aggregate.
- Two sources continuously valid alternate A, B, A, … starting from rr.
- Simultaneous push and pop on one queue keeps count unchanged. A push into an empty queue is not eligible for the pop on that same edge.
- protErr and pending change only on posedge or on reset assertion.
- After reset release: ready = 0 in the first cycle and 1 in the second.

## Structure
- Package regfile_pkg holds:
  - NREG = 16 and REG_W = 4
  - DATA_W and PROT_MASK defaults
  - source enum SRC_A = 0, SRC_B = 1
- Sub-module wb_fifo (DEPTH, width REG_W+DATA_W) is instantiated twice. It provides push, pop, head, count, and a per-entry valid vector and reg vector for the pending decode.
- Arbitration, issue registers, protErr and pending live in the top level.

## Test plan
- Reset then idle: all outputs 0 during reset. Ready = 0 in the first cycle after release, then 1. writeEnable stays 0.
- Single A write r3 = 0xDEADBEEF at edge N:
  - writeEnable = 1, dReg = 3, wrData = 0xDEADBEEF, wb_src = 0 after edge N+1.
  - pending[3] = 1 from after N until writeEnable drops.
- Both sources hold valid for 6 cycles (A → r1..r6, B → r7..r12):
  - grants alternate A, B, A, … with one write per cycle.
  - a_ready/b_ready drop when the queues reach DEPTH = 2.
  - every write appears exactly once, in per-source order.
- B write to r14, A write to r15 in the same cycle: both handshakes complete, no writeEnable, one protErr pulse, pending stays 0.
- Fill queue A to full, assert reset mid-stream: after reset, queue A is empty, writeEnable = 0 and pending = 0. The next write r5 = 7 issues normally with latency 2.
